// File: rtl/alu_req_arbiter_if.sv
// Purpose: request/ALU/response bundle between command sources, the ALU arbiter and the ALU.
// Latency: n/a (wires only).
// Backpressure: n/a; req_valid/req_ready and rsp_valid/rsp_ready handshakes are carried here.
// Ports: req_* (per-requester op + handshake), alu_* (ALU input bus, res/flags back),
//        rsp_* (tagged result + handshake), busy. master = arbiter side, slave = environment.
interface alu_req_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_mode;
  logic [4*NUM_REQ-1:0]     req_cmd;
  logic [WIDTH*NUM_REQ-1:0] req_opa;
  logic [WIDTH*NUM_REQ-1:0] req_opb;
  logic [NUM_REQ-1:0]       req_cin;

  logic [1:0]               alu_inp_valid;
  logic                     alu_mode;
  logic [3:0]               alu_cmd;
  logic                     alu_ce;
  logic [WIDTH-1:0]         alu_opa;
  logic [WIDTH-1:0]         alu_opb;
  logic                     alu_cin;
  logic [WIDTH:0]           alu_res;
  logic [5:0]               alu_flags;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH:0]           rsp_res;
  logic [5:0]               rsp_flags;
  logic                     busy;

  modport master (
    input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin,
    input  alu_res, alu_flags, rsp_ready,
    output req_ready,
    output alu_inp_valid, alu_mode, alu_cmd, alu_ce, alu_opa, alu_opb, alu_cin,
    output rsp_valid, rsp_id, rsp_res, rsp_flags, busy
  );

  modport slave (
    output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin,
    output alu_res, alu_flags, rsp_ready,
    input  req_ready,
    input  alu_inp_valid, alu_mode, alu_cmd, alu_ce, alu_opa, alu_opb, alu_cin,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Purpose: round-robin share of one ALU among NUM_REQ requesters, results returned tagged with requester id.
// Latency: 1 (IDLE accept) + ALU_LAT or MUL_LAT (ISSUE/WAIT) + 1 (RESP) cycles per op with rsp_ready high.
// Backpressure: req_ready only in IDLE (one op in flight); RESP holds rsp_* until rsp_ready.
// Ports: clk, rst (async, active low); bus (master): req_* in / req_ready out, alu_* bus out with
//        alu_res/alu_flags in, rsp_valid/rsp_id/rsp_res/rsp_flags out with rsp_ready in, busy out.
module alu_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_req_arbiter_if.master bus
);
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXLAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [IDW-1:0]     RR_RST  = IDW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0]    ALU_CNT = CNTW'(ALU_LAT - 1);
  localparam logic [CNTW-1:0]    MUL_CNT = CNTW'(MUL_LAT - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    rr_ptr;     // last granted requester; also owner of the op in flight
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_vld;
  logic [CNTW-1:0]   cnt;
  logic              accept, capture;
  logic              g_mode;
  logic [3:0]        g_cmd;
  logic              g_is_mul;

  logic              lat_mode, lat_cin;
  logic [3:0]        lat_cmd;
  logic [WIDTH-1:0]  lat_opa, lat_opb;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH:0]    rsp_res_q;
  logic [5:0]        rsp_flags_q;

  // Search downward from the farthest slot so the nearest requester after rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign g_mode   = bus.req_mode[gnt_idx];
  assign g_cmd    = bus.req_cmd[int'(gnt_idx)*4 +: 4];
  assign g_is_mul = g_mode && ((g_cmd == 4'd9) || (g_cmd == 4'd10));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // cnt holds the remaining ALU cycles minus one; capture happens on the
  // edge leaving the last ISSUE/WAIT cycle.
  always_comb begin
    state_nxt         = state;
    bus.req_ready     = '0;
    bus.alu_ce        = 1'b0;
    bus.alu_inp_valid = 2'b00;
    accept            = 1'b0;
    capture           = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          bus.req_ready = ONE << gnt_idx;
          accept        = 1'b1;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        bus.alu_ce        = 1'b1;
        bus.alu_inp_valid = 2'b11;
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        bus.alu_ce = 1'b1;
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held the state is IDLE; keep req_ready low so nothing looks accepted.
    if (!rst) bus.req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= RR_RST;
      cnt         <= '0;
      lat_mode    <= 1'b0;
      lat_cmd     <= '0;
      lat_opa     <= '0;
      lat_opb     <= '0;
      lat_cin     <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr   <= gnt_idx;
        lat_mode <= g_mode;
        lat_cmd  <= g_cmd;
        lat_opa  <= bus.req_opa[int'(gnt_idx)*WIDTH +: WIDTH];
        lat_opb  <= bus.req_opb[int'(gnt_idx)*WIDTH +: WIDTH];
        lat_cin  <= bus.req_cin[gnt_idx];
        cnt      <= g_is_mul ? MUL_CNT : ALU_CNT;
      end else if (((state == ISSUE) || (state == WAIT)) && (cnt != '0)) begin
        cnt <= cnt - CNTW'(1);
      end
      if (capture) begin
        rsp_id_q    <= rr_ptr;
        rsp_res_q   <= bus.alu_res;
        rsp_flags_q <= bus.alu_flags;
      end
    end
  end

  assign bus.alu_mode  = lat_mode;
  assign bus.alu_cmd   = lat_cmd;
  assign bus.alu_opa   = lat_opa;
  assign bus.alu_opb   = lat_opb;
  assign bus.alu_cin   = lat_cin;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Purpose: directed self-checking bench for alu_req_arbiter with a cycle-accurate ALU model.
// Latency: ALU model drives valid res only in the cycle the arbiter must sample it.
// Backpressure: rsp_ready driven by the directed sequence.
module tb_alu_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_req_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

  alu_req_arbiter #(.WIDTH(8), .NUM_REQ(4), .ALU_LAT(1), .MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [8:0] res;
    logic [5:0] flags;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rr_model = 3;
  int   cyc_cnt  = 0;
  int   iv_cnt   = 0;
  logic [2:0] age = 3'd0;
  logic [2:0] cur, lat_now;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clk) if (bus.alu_inp_valid == 2'b11) iv_cnt <= iv_cnt + 1;

  // {res[8:0], err, oflow, cout, g, l, e}
  function automatic logic [14:0] alu_model(input logic m, input logic [3:0] c,
                                            input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] r;
    logic err, ofl, co;
    r = 9'd0; err = 1'b0; ofl = 1'b0; co = 1'b0;
    if (m) begin
      case (c)
        4'd0:  begin r = {1'b0, a} + {1'b0, b}; co = r[8]; end
        4'd1:  begin r = {1'b0, a} - {1'b0, b}; ofl = (a < b); end
        4'd2:  begin r = {1'b0, a} + {1'b0, b} + {8'd0, ci}; co = r[8]; end
        4'd9:  r = 9'(16'(a) * 16'(b));
        4'd10: r = 9'((16'(a) << 1) * 16'(b));
        default: err = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0: r = {1'b0, a & b};
        4'd1: r = {1'b0, a | b};
        4'd2: r = {1'b0, a ^ b};
        default: err = 1'b1;
      endcase
    end
    return {r, err, ofl, co, (a > b), (a < b), (a == b)};
  endfunction

  // ALU stand-in: correct result only in the cycle the op is due, garbage otherwise.
  always @(posedge clk or negedge rst) begin
    if (!rst)                                age <= 3'd0;
    else if (bus.alu_inp_valid == 2'b11)     age <= 3'd1;
    else if (age != 3'd0 && bus.alu_ce)      age <= age + 3'd1;
    else                                     age <= 3'd0;
  end

  always_comb begin
    cur     = (bus.alu_inp_valid == 2'b11) ? 3'd1 : ((age != 3'd0) ? age + 3'd1 : 3'd0);
    lat_now = (bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10)) ? 3'd2 : 3'd1;
    if (cur == lat_now)
      {bus.alu_res, bus.alu_flags} = alu_model(bus.alu_mode, bus.alu_cmd, bus.alu_opa, bus.alu_opb, bus.alu_cin);
    else
      {bus.alu_res, bus.alu_flags} = {9'h155, 6'h2A};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int predict_grant(input logic [3:0] v, input int rr);
    for (int k = 1; k <= 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.req_mode[i]       = m;
    bus.req_cmd[4*i +: 4] = c;
    bus.req_opa[8*i +: 8] = a;
    bus.req_opb[8*i +: 8] = b;
    bus.req_cin[i]        = ci;
    bus.req_valid[i]      = 1'b1;
  endtask

  // Call at posedge+1; returns in the accepting cycle, before its edge.
  task automatic accept_one(input int bound, output int gid, output logic [3:0] rdy);
    int g;
    exp_t e;
    logic [14:0] m;
    bit done;
    gid = -1; rdy = '0; done = 0;
    for (int c = 0; c < bound && !done; c++) begin
      #1;
      if (bus.busy === 1'b0) begin
        g = predict_grant(bus.req_valid, rr_model);
        check("req_ready_idle", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
          m = alu_model(bus.req_mode[g], bus.req_cmd[4*g +: 4], bus.req_opa[8*g +: 8],
                        bus.req_opb[8*g +: 8], bus.req_cin[g]);
          e.id    = g;
          e.res   = m[14:6];
          e.flags = m[5:0];
          e.lat   = (bus.req_mode[g] && (bus.req_cmd[4*g +: 4] == 4'd9 || bus.req_cmd[4*g +: 4] == 4'd10)) ? 2 : 1;
          e.acc   = cyc_cnt;
          sbq.push_back(e);
          rr_model = g; gid = g; rdy = bus.req_ready; done = 1;
        end
      end else begin
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      end
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  // Returns in the first RESP cycle, after checking it against the scoreboard.
  task automatic get_rsp(input int bound);
    exp_t e;
    bit done;
    done = 0;
    for (int c = 0; c < bound && !done; c++) begin
      #1;
      if (bus.rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_res", 32'(bus.rsp_res), 32'(e.res));
          check("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
          check("rsp_latency", 32'(cyc_cnt - e.acc), 32'(e.lat + 1));
        end
        check("req_ready_resp", 32'(bus.req_ready), 32'd0);
        done = 1;
      end else begin
        if (bus.busy === 1'b1) check("req_ready_wait", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    if (!done) check("rsp_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid, iv0, hs;
    logic [3:0] rdy;
    logic [14:0] mexp;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    bus.req_valid = '0; bus.req_mode = '0; bus.req_cmd = '0;
    bus.req_opa = '0; bus.req_opb = '0; bus.req_cin = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with a request pending.
    #2;
    bus.req_valid = 4'b0010;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_iv", 32'(bus.alu_inp_valid), 32'd0);
    check("rst_alu_ce", 32'(bus.alu_ce), 32'd0);
    bus.req_valid = '0;
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Single ADD from requester 1.
    set_req(1, 1'b1, 4'd0, 8'hF0, 8'h20, 1'b0);
    accept_one(20, gid, rdy);
    check("t2_grant", 32'(rdy), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    #1;
    check("t2_issue_iv", 32'(bus.alu_inp_valid), 32'd3);
    check("t2_issue_opa", 32'(bus.alu_opa), 32'hF0);
    get_rsp(20);
    check("t2_res", 32'(bus.rsp_res), 32'h110);
    check("t2_cout", 32'(bus.rsp_flags[3]), 32'd1);
    @(posedge clk); #1;

    // Multiply latency on requester 3.
    set_req(3, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
    iv0 = iv_cnt;
    accept_one(20, gid, rdy);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    get_rsp(20);
    check("t4_res", 32'(bus.rsp_res), 32'd12);
    check("t4_iv_cycles", 32'(iv_cnt - iv0), 32'd1);
    @(posedge clk); #1;

    // Fairness: all requesters valid continuously.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd0, 8'(i * 16 + 1), 8'(i + 2), 1'b0);
    for (int k = 0; k < 5; k++) begin
      accept_one(20, gid, rdy);
      check("t3_order", 32'(rdy), 32'd1 << order[k]);
      @(posedge clk); #1;
      if (gid >= 0) bus.req_opa[8*gid +: 8] = bus.req_opa[8*gid +: 8] + 8'h11;
      get_rsp(20);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;

    // Backpressure: response held 5 cycles while another requester waits.
    set_req(2, 1'b0, 4'd2, 8'hA5, 8'h3C, 1'b0);
    mexp = alu_model(1'b0, 4'd2, 8'hA5, 8'h3C, 1'b0);
    accept_one(20, gid, rdy);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    set_req(1, 1'b1, 4'd2, 8'h7F, 8'h01, 1'b1);
    bus.rsp_ready = 1'b0;
    get_rsp(20);
    iv0 = iv_cnt;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("t5_rsp_id", 32'(bus.rsp_id), 32'd2);
      check("t5_rsp_res", 32'(bus.rsp_res), 32'(mexp[14:6]));
      check("t5_rsp_flags", 32'(bus.rsp_flags), 32'(mexp[5:0]));
      check("t5_req_ready", 32'(bus.req_ready), 32'd0);
      check("t5_alu_ce", 32'(bus.alu_ce), 32'd0);
    end
    check("t5_no_issue", 32'(iv_cnt - iv0), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    accept_one(20, gid, rdy);
    check("t5_next_grant", 32'(rdy), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    get_rsp(20);
    @(posedge clk); #1;

    // Request arriving in the response handshake cycle.
    set_req(0, 1'b1, 4'd1, 8'h10, 8'h30, 1'b0);
    accept_one(20, gid, rdy);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready = 1'b0;
    get_rsp(20);
    @(posedge clk); #1;
    set_req(2, 1'b1, 4'd10, 8'd5, 8'd6, 1'b0);
    bus.rsp_ready = 1'b1;
    #1;
    check("t6_hs_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t6_hs_req_ready", 32'(bus.req_ready), 32'd0);
    hs = cyc_cnt;
    @(posedge clk); #1;
    accept_one(20, gid, rdy);
    check("t6_accept_cycle", 32'(cyc_cnt), 32'(hs + 1));
    check("t6_grant", 32'(rdy), 32'b0100);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    get_rsp(20);
    check("t6_res", 32'(bus.rsp_res), 32'd60);
    @(posedge clk); #1;

    // Reset in the middle of a multiply WAIT.
    set_req(0, 1'b1, 4'd9, 8'd7, 8'd9, 1'b0);
    accept_one(20, gid, rdy);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("t1_wait_busy", 32'(bus.busy), 32'd1);
    check("t1_wait_ce", 32'(bus.alu_ce), 32'd1);
    check("t1_wait_iv", 32'(bus.alu_inp_valid), 32'd0);
    set_req(0, 1'b1, 4'd0, 8'h11, 8'h22, 1'b0);
    set_req(1, 1'b1, 4'd0, 8'h33, 8'h44, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("t1_rst_busy", 32'(bus.busy), 32'd0);
    check("t1_rst_ce", 32'(bus.alu_ce), 32'd0);
    check("t1_rst_iv", 32'(bus.alu_inp_valid), 32'd0);
    check("t1_rst_opa", 32'(bus.alu_opa), 32'd0);
    check("t1_rst_cmd", 32'(bus.alu_cmd), 32'd0);
    check("t1_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("t1_rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags}), 32'd0);
    sbq.delete();
    rr_model = 3;
    bus.req_valid = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      check("t1_post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t1_post_busy", 32'(bus.busy), 32'd0);
    end
    set_req(0, 1'b1, 4'd0, 8'h11, 8'h22, 1'b0);
    set_req(1, 1'b1, 4'd0, 8'h33, 8'h44, 1'b0);
    accept_one(20, gid, rdy);
    check("t1_first_grant", 32'(rdy), 32'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    get_rsp(20);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
